// File: rtl/aqed_pkg.sv
// rtl/aqed_pkg.sv - shared types and default widths for the A-QED functional-consistency tracker
package aqed_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int IDX_W_DEF  = 16;
  localparam int RB_CYC_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ORIG = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } fc_state_t;

endpackage

// File: rtl/aqed_fc_tracker_if.sv
// rtl/aqed_fc_tracker_if.sv - observed core streams and tracker verdict signals
interface aqed_fc_tracker_if #(
  parameter int DATA_W = aqed_pkg::DATA_W_DEF
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              orig_mark;
  logic              exec_dup;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              qed_done;
  logic              qed_check;
  logic              rb_fail;

  modport master (
    output in_data, in_valid, orig_mark, exec_dup, out_data, out_valid,
    input  qed_done, qed_check, rb_fail
  );

  modport slave (
    input  in_data, in_valid, orig_mark, exec_dup, out_data, out_valid,
    output qed_done, qed_check, rb_fail
  );

endinterface

// File: rtl/aqed_sat_counter.sv
// rtl/aqed_sat_counter.sv - stream position counter that sticks at all-ones
module aqed_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && !sat) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign sat   = &count_q;
  assign count = count_q;

endmodule

// File: rtl/aqed_fc_tracker.sv
// rtl/aqed_fc_tracker.sv - A-QED original/duplicate capture and compare; AQED_RESP_BOUND_EN adds a response bound
module aqed_fc_tracker
  import aqed_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int RB_CYC = RB_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  aqed_fc_tracker_if.slave  bus
);

  logic [IDX_W-1:0]  in_idx, out_idx;
  logic              in_sat, out_sat;

  fc_state_t         state_q, state_d;
  logic [IDX_W-1:0]  orig_idx_q, orig_idx_d, dup_idx_q, dup_idx_d;
  logic [DATA_W-1:0] orig_in_q, orig_in_d;
  logic [DATA_W-1:0] orig_out_q, orig_out_d, dup_out_q, dup_out_d;
  logic              orig_got_q, orig_got_d, dup_got_q, dup_got_d;
  logic              done_q, done_d, check_q, check_d;

  logic              tag_ok, cap_ok, orig_hit, dup_hit;

  aqed_sat_counter #(.W(IDX_W)) u_in_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.in_valid),
    .count (in_idx),
    .sat   (in_sat)
  );

  aqed_sat_counter #(.W(IDX_W)) u_out_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.out_valid),
    .count (out_idx),
    .sat   (out_sat)
  );

  // A saturated position is ambiguous, so it can neither be tagged nor captured.
  assign tag_ok   = bus.in_valid && !in_sat;
  assign cap_ok   = bus.out_valid && !out_sat;
  assign orig_hit = cap_ok && (out_idx == orig_idx_q) && !orig_got_q;
  assign dup_hit  = cap_ok && (out_idx == dup_idx_q) && !dup_got_q;

  always_comb begin
    state_d    = state_q;
    orig_idx_d = orig_idx_q;
    dup_idx_d  = dup_idx_q;
    orig_in_d  = orig_in_q;
    orig_out_d = orig_out_q;
    dup_out_d  = dup_out_q;
    orig_got_d = orig_got_q;
    dup_got_d  = dup_got_q;
    done_d     = done_q;
    check_d    = check_q;
    case (state_q)
      IDLE: begin
        if (tag_ok && bus.orig_mark) begin
          orig_idx_d = in_idx;
          orig_in_d  = bus.in_data;
          state_d    = ORIG;
        end
      end
      ORIG: begin
        if (orig_hit) begin
          orig_out_d = bus.out_data;
          orig_got_d = 1'b1;
        end
        if (tag_ok && bus.exec_dup && (bus.in_data == orig_in_q)) begin
          dup_idx_d = in_idx;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (orig_hit) begin
          orig_out_d = bus.out_data;
          orig_got_d = 1'b1;
        end
        if (dup_hit) begin
          dup_out_d = bus.out_data;
          dup_got_d = 1'b1;
        end
        if (orig_got_d && dup_got_d) begin
          state_d = DONE;
          done_d  = 1'b1;
          check_d = (orig_out_d == dup_out_d);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      orig_idx_q <= '0;
      dup_idx_q  <= '0;
      orig_in_q  <= '0;
      orig_out_q <= '0;
      dup_out_q  <= '0;
      orig_got_q <= 1'b0;
      dup_got_q  <= 1'b0;
      done_q     <= 1'b0;
      check_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      orig_idx_q <= orig_idx_d;
      dup_idx_q  <= dup_idx_d;
      orig_in_q  <= orig_in_d;
      orig_out_q <= orig_out_d;
      dup_out_q  <= dup_out_d;
      orig_got_q <= orig_got_d;
      dup_got_q  <= dup_got_d;
      done_q     <= done_d;
      check_q    <= check_d;
    end
  end

  assign bus.qed_done  = done_q;
  assign bus.qed_check = check_q;

`ifdef AQED_RESP_BOUND_EN
  localparam int RB_W = $clog2(RB_CYC + 1);

  logic [RB_W-1:0] rb_cnt_q, rb_cnt_d;
  logic            rb_fail_q;

  // Counter restarts on WAIT entry and parks at the bound so it cannot wrap.
  always_comb begin
    rb_cnt_d = rb_cnt_q;
    if (state_d == WAIT) begin
      if (state_q != WAIT) begin
        rb_cnt_d = '0;
      end else if (rb_cnt_q != RB_W'(RB_CYC)) begin
        rb_cnt_d = rb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_cnt_q  <= '0;
      rb_fail_q <= 1'b0;
    end else begin
      rb_cnt_q  <= rb_cnt_d;
      rb_fail_q <= rb_fail_q || ((state_d == WAIT) && (rb_cnt_d == RB_W'(RB_CYC)));
    end
  end

  assign bus.rb_fail = rb_fail_q;
`else
  assign bus.rb_fail = 1'b0;
`endif

endmodule

// File: tb/tb_aqed_fc_tracker.sv
// tb/tb_aqed_fc_tracker.sv - scoreboard bench for aqed_fc_tracker with directed stream vectors
module tb_aqed_fc_tracker;

  typedef struct {
    logic chk;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic seen = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aqed_fc_tracker_if #(.DATA_W(16)) bus ();

  aqed_fc_tracker #(.DATA_W(16), .IDX_W(4), .RB_CYC(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: every rising qed_done consumes one expectation.
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else if (bus.qed_done && !seen) begin
      seen = 1'b1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.qed_check !== e.chk || cyc != e.cyc) begin
          errors++;
          $display("FAIL done_event: got check=%0b cycle=%0d expected check=%0b cycle=%0d",
                   bus.qed_check, cyc, e.chk, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid  = 1'b0;
    bus.orig_mark = 1'b0;
    bus.exec_dup  = 1'b0;
    bus.out_valid = 1'b0;
  endtask

  task automatic feed_in(input logic [15:0] d, input logic om, input logic ed);
    bus.in_data   = d;
    bus.in_valid  = 1'b1;
    bus.orig_mark = om;
    bus.exec_dup  = ed;
    step();
    idle_in();
  endtask

  task automatic feed_out(input logic [15:0] d, input logic expect_done, input logic exp_chk);
    exp_t e;
    if (expect_done) begin
      e.chk = exp_chk;
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    bus.out_data  = d;
    bus.out_valid = 1'b1;
    step();
    idle_in();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    chk("reset_done", 32'(bus.qed_done), 32'h0);
    chk("reset_check", 32'(bus.qed_check), 32'h1);
    chk("reset_rb_fail", 32'(bus.rb_fail), 32'h0);
    reset = 1'b0;
  endtask

  task automatic finish_case(input string name);
    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d outstanding expectations expected 0", name, sb.size());
    end
    sb.delete();
  endtask

  initial begin
    int c0;
    bus.in_data  = '0;
    bus.out_data = '0;
    idle_in();
    do_reset();

    // Match: 11,22,11 tagged at 0 and 2, echoed in order
    feed_in(16'h11, 1, 0);
    feed_in(16'h22, 0, 0);
    feed_in(16'h11, 0, 1);
    feed_out(16'h11, 0, 0);
    feed_out(16'h22, 0, 0);
    feed_out(16'h11, 1, 1);
    finish_case("match");
    chk("match_done_held", 32'(bus.qed_done), 32'h1);

    // Asynchronous reset while done is high
    #2 reset = 1'b1;
    #1;
    chk("async_done", 32'(bus.qed_done), 32'h0);
    chk("async_check", 32'(bus.qed_check), 32'h1);
    chk("async_rb_fail", 32'(bus.rb_fail), 32'h0);
    step();
    do_reset();

    // Mismatch at the duplicate position
    feed_in(16'h11, 1, 0);
    feed_in(16'h22, 0, 0);
    feed_in(16'h11, 0, 1);
    feed_out(16'h11, 0, 0);
    feed_out(16'h22, 0, 0);
    feed_out(16'h12, 1, 0);
    finish_case("mismatch");
    chk("mismatch_check_held", 32'(bus.qed_check), 32'h0);
    do_reset();

    // Dup tag on a different value is ignored; later valid dup at idx3
    feed_in(16'h11, 1, 0);
    feed_in(16'h22, 0, 1);
    feed_in(16'h33, 0, 0);
    feed_in(16'h11, 0, 1);
    feed_out(16'h11, 0, 0);
    feed_out(16'h22, 0, 0);
    feed_out(16'h33, 0, 0);
    feed_out(16'h11, 1, 1);
    finish_case("bad_dup");
    do_reset();

    // Both tags on the same word: orig only, no completion
    feed_in(16'h11, 1, 1);
    feed_in(16'h11, 0, 0);
    feed_out(16'h11, 0, 0);
    feed_out(16'h11, 0, 0);
    finish_case("simul_tags");
    chk("simul_no_done", 32'(bus.qed_done), 32'h0);
    do_reset();

    // Original output arrives while still in ORIG
    feed_in(16'h5A, 1, 0);
    feed_out(16'h5A, 0, 0);
    feed_in(16'h77, 0, 0);
    feed_in(16'h5A, 0, 1);
    feed_out(16'h77, 0, 0);
    feed_out(16'h5A, 1, 1);
    finish_case("early_orig");
    do_reset();

    feed_in(16'h5A, 1, 0);
    feed_out(16'h5B, 0, 0);
    feed_in(16'h77, 0, 0);
    feed_in(16'h5A, 0, 1);
    feed_out(16'h77, 0, 0);
    feed_out(16'h5A, 1, 0);
    finish_case("early_orig_mis");
    do_reset();

    // Idle gaps on both streams do not advance positions
    feed_in(16'h33, 1, 0);
    step();
    feed_in(16'h44, 0, 0);
    step();
    feed_in(16'h33, 0, 1);
    feed_out(16'h33, 0, 0);
    step();
    feed_out(16'h44, 0, 0);
    step();
    feed_out(16'h33, 1, 1);
    finish_case("gaps");
    do_reset();

    // Last usable positions before saturation (IDX_W=4: 15 is saturated)
    for (int i = 0; i < 13; i++) feed_in(16'h01, 0, 0);
    feed_in(16'h99, 1, 0);
    feed_in(16'h99, 0, 1);
    for (int i = 0; i < 13; i++) feed_out(16'h01, 0, 0);
    feed_out(16'h99, 0, 0);
    feed_out(16'h99, 1, 1);
    finish_case("near_sat");
    do_reset();

    // Duplicate on the saturated position is refused
    for (int i = 0; i < 14; i++) feed_in(16'h02, 0, 0);
    feed_in(16'h99, 1, 0);
    feed_in(16'h99, 0, 1);
    feed_in(16'h99, 0, 1);
    for (int i = 0; i < 17; i++) feed_out(16'h99, 0, 0);
    finish_case("sat_dup");
    chk("sat_no_done", 32'(bus.qed_done), 32'h0);
    do_reset();

`ifdef AQED_RESP_BOUND_EN
    // Response bound: WAIT entered, no outputs
    feed_in(16'h11, 1, 0);
    c0 = cyc;
    feed_in(16'h11, 0, 1);
    while (cyc < c0 + 8) step();
    chk("rb_before_bound", 32'(bus.rb_fail), 32'h0);
    step();
    chk("rb_at_bound", 32'(bus.rb_fail), 32'h1);
    repeat (4) step();
    chk("rb_sticky", 32'(bus.rb_fail), 32'h1);
    finish_case("rb");
    do_reset();
`else
    c0 = 0;
    feed_in(16'h11, 1, 0);
    feed_in(16'h11, 0, 1);
    repeat (20) step();
    chk("rb_tied_off", 32'(bus.rb_fail) + 32'(c0), 32'h0);
    finish_case("rb_off");
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
